// File: rtl/carousel_word_packer_if.sv
// Handshake bundle between a serial word producer, the packer and the rotator's parallel input.
// CAROUSEL_PACKER_FLUSH_EN adds the data_in_last sideband.
interface carousel_word_packer_if #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned BUFFER_SIZE = 16
);
    logic [WIDTH-1:0] data_in;
    logic             data_in_valid;
    logic             data_in_ready;
`ifdef CAROUSEL_PACKER_FLUSH_EN
    logic             data_in_last;
`endif
    logic [WIDTH-1:0] data_out [BUFFER_SIZE-1:0];
    logic             data_out_valid;
    logic             data_out_ready;

`ifdef CAROUSEL_PACKER_FLUSH_EN
    modport master (
        output data_in, data_in_valid, data_in_last, data_out_ready,
        input  data_in_ready, data_out, data_out_valid
    );
    modport slave (
        input  data_in, data_in_valid, data_in_last, data_out_ready,
        output data_in_ready, data_out, data_out_valid
    );
`else
    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid
    );
    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid
    );
`endif
endinterface

// File: rtl/carousel_word_packer.sv
// Ping-pong serial-to-parallel packer feeding the carousel rotator.
// Define CAROUSEL_PACKER_FLUSH_EN to close a partial vector early with data_in_last.
module carousel_word_packer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned BUFFER_SIZE = 16
) (
    input logic                   clk,
    input logic                   rst,
    carousel_word_packer_if.slave bus
);
    localparam int unsigned      CNT_W     = $clog2(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BUFFER_SIZE - 1);

    logic [WIDTH-1:0] bank_q [2][BUFFER_SIZE];
    logic [WIDTH-1:0] bank_d [2][BUFFER_SIZE];
    logic [1:0]       full_q, full_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             in_fire, out_fire, flush, close_bank;

`ifdef CAROUSEL_PACKER_FLUSH_EN
    assign flush = bus.data_in_last;
`else
    assign flush = 1'b0;
`endif

    // Ready and valid depend only on registers, never on the opposite side's inputs.
    assign bus.data_in_ready  = ~full_q[wr_sel_q];
    assign bus.data_out_valid = full_q[rd_sel_q];

    assign in_fire    = bus.data_in_valid & ~full_q[wr_sel_q];
    assign out_fire   = bus.data_out_ready & full_q[rd_sel_q];
    assign close_bank = (fill_cnt_q == LAST_LANE) | flush;

    always_comb begin
        for (int l = 0; l < BUFFER_SIZE; l++) begin
            bus.data_out[l] = bank_q[rd_sel_q][l];
        end
    end

    always_comb begin
        bank_d     = bank_q;
        full_d     = full_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        fill_cnt_d = fill_cnt_q;

        // A draining bank is always full and a filling bank never is, so the two never collide.
        if (out_fire) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end

        if (in_fire) begin
            for (int l = 0; l < BUFFER_SIZE; l++) begin
                if (CNT_W'(l) == fill_cnt_q) begin
                    bank_d[wr_sel_q][l] = bus.data_in;
                end else if (flush && (CNT_W'(l) > fill_cnt_q)) begin
                    bank_d[wr_sel_q][l] = '0;
                end
            end
            if (close_bank) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
                fill_cnt_d       = '0;
            end else begin
                fill_cnt_d = fill_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int l = 0; l < BUFFER_SIZE; l++) begin
                    bank_q[b][l] <= '0;
                end
            end
            full_q     <= 2'b00;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            fill_cnt_q <= '0;
        end else begin
            bank_q     <= bank_d;
            full_q     <= full_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end
endmodule

// File: tb/tb_carousel_word_packer.sv
// Self-checking bench for carousel_word_packer: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_carousel_word_packer;
    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    carousel_word_packer_if #(.WIDTH(W), .BUFFER_SIZE(N)) bus ();

    carousel_word_packer #(.WIDTH(W), .BUFFER_SIZE(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: completed vectors awaiting the consumer, and the partial fill.
    logic [W*N-1:0] pend [$];
    logic [W-1:0]   cur [$];

    typedef struct {
        logic [W-1:0]   din;
        bit             vin;
        bit             rout;
        bit             exp_in_ready;
        bit             exp_out_valid;
        logic [W*N-1:0] exp_vec;
    } row_t;

    row_t tbl [$];

    function automatic logic [W*N-1:0] dut_vec();
        logic [W*N-1:0] v;
        for (int l = 0; l < N; l++) v[l*W +: W] = bus.data_out[l];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_inputs(input logic [W-1:0] din, input bit vin, input bit rout,
                              input bit last);
        bus.data_in        = din;
        bus.data_in_valid  = vin;
        bus.data_out_ready = rout;
`ifdef CAROUSEL_PACKER_FLUSH_EN
        bus.data_in_last   = last;
`else
        if (last) $display("note: data_in_last ignored in this build");
`endif
    endtask

    // One clock cycle: compare outputs with the model at negedge, apply inputs, advance model.
    task automatic drive_cycle(input logic [W-1:0] din, input bit vin, input bit rout,
                               input bit last, input string tag);
        bit in_fire, out_fire;
        logic [W*N-1:0] v;
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(bus.data_in_ready), 64'(pend.size() < 2));
        check({tag, ".out_valid"}, 64'(bus.data_out_valid), 64'(pend.size() > 0));
        if (pend.size() > 0) check({tag, ".data_out"}, 64'(dut_vec()), 64'(pend[0]));
        set_inputs(din, vin, rout, last);
        in_fire  = vin && (pend.size() < 2);
        out_fire = rout && (pend.size() > 0);
        @(posedge clk);
        if (out_fire) void'(pend.pop_front());
        if (in_fire) begin
            cur.push_back(din);
`ifdef CAROUSEL_PACKER_FLUSH_EN
            if (last) while (cur.size() < N) cur.push_back('0);
`endif
            if (cur.size() == N) begin
                for (int l = 0; l < N; l++) v[l*W +: W] = cur[l];
                pend.push_back(v);
                cur.delete();
            end
        end
    endtask

    function automatic row_t mk(input logic [W-1:0] din, input bit vin, input bit rout,
                                input bit er, input bit ev, input logic [W*N-1:0] vec);
        row_t r;
        r.din = din; r.vin = vin; r.rout = rout;
        r.exp_in_ready = er; r.exp_out_valid = ev; r.exp_vec = vec;
        return r;
    endfunction

    initial begin
        set_inputs('0, 1'b0, 1'b0, 1'b0);

        // Directed vectors: expectations are the outputs seen before the edge that applies the row.
        tbl.push_back(mk(8'h11, 1, 1, 1, 0, '0));
        tbl.push_back(mk(8'h22, 1, 1, 1, 0, '0));
        tbl.push_back(mk(8'h33, 1, 1, 1, 0, '0));
        tbl.push_back(mk(8'h44, 1, 1, 1, 0, '0));
        tbl.push_back(mk(8'h00, 0, 1, 1, 1, 32'h44332211));
        tbl.push_back(mk(8'h00, 0, 1, 1, 0, '0));
        for (int i = 1; i <= 4; i++) tbl.push_back(mk(W'(i), 1, 0, 1, 0, '0));
        for (int i = 5; i <= 8; i++) tbl.push_back(mk(W'(i), 1, 0, 1, 1, 32'h04030201));
        tbl.push_back(mk(8'h09, 1, 0, 0, 1, 32'h04030201));
        tbl.push_back(mk(8'h09, 1, 1, 0, 1, 32'h04030201));
        tbl.push_back(mk(8'h09, 1, 0, 1, 1, 32'h08070605));
        tbl.push_back(mk(8'h0A, 1, 1, 1, 1, 32'h08070605));
        tbl.push_back(mk(8'h0B, 1, 1, 1, 0, '0));
        tbl.push_back(mk(8'h0C, 1, 1, 1, 0, '0));
        tbl.push_back(mk(8'h00, 0, 1, 1, 1, 32'h0C0B0A09));
        tbl.push_back(mk(8'h00, 0, 1, 1, 0, '0));

        #2;
        check("reset.in_ready", 64'(bus.data_in_ready), 64'(1));
        check("reset.out_valid", 64'(bus.data_out_valid), 64'(0));
        check("reset.data_out", 64'(dut_vec()), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            check($sformatf("tbl%0d.in_ready", i), 64'(bus.data_in_ready),
                  64'(tbl[i].exp_in_ready));
            check($sformatf("tbl%0d.out_valid", i), 64'(bus.data_out_valid),
                  64'(tbl[i].exp_out_valid));
            if (tbl[i].exp_out_valid)
                check($sformatf("tbl%0d.data_out", i), 64'(dut_vec()), 64'(tbl[i].exp_vec));
            set_inputs(tbl[i].din, tbl[i].vin, tbl[i].rout, 1'b0);
        end

        // Sustained one word per cycle with an always-ready consumer.
        for (int i = 0; i < 40; i++) drive_cycle(W'($urandom), 1, 1, 0, "stream");

        // Random valid/ready traffic; the model checks hold-stability and ordering.
        for (int i = 0; i < 300; i++)
            drive_cycle(W'($urandom), 1'($urandom), 1'($urandom), 0, "random");
        for (int i = 0; i < 4; i++) drive_cycle('0, 0, 1, 0, "drain");

        // Asynchronous reset in the middle of a fill while a vector is waiting.
        for (int i = 0; i < 6; i++) drive_cycle(W'(8'hC0 + i), 1, 0, 0, "prefill");
        drive_cycle('0, 0, 0, 0, "prefill_idle");
        check("pre_rst.out_valid", 64'(bus.data_out_valid), 64'(1));
        #3 rst = 1'b0;
        #1;
        check("async_rst.out_valid", 64'(bus.data_out_valid), 64'(0));
        check("async_rst.in_ready", 64'(bus.data_in_ready), 64'(1));
        check("async_rst.data_out", 64'(dut_vec()), 64'(0));
        pend.delete();
        cur.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) drive_cycle(W'(8'hA0 + i), 1, 0, 0, "post_rst");
        @(negedge clk);
        check("post_rst.vec_valid", 64'(bus.data_out_valid), 64'(1));
        check("post_rst.vec", 64'(dut_vec()), 64'(32'hA3A2A1A0));
        drive_cycle('0, 0, 1, 0, "post_rst_drain");

`ifdef CAROUSEL_PACKER_FLUSH_EN
        drive_cycle(8'h55, 1, 1, 0, "flush");
        drive_cycle(8'h66, 1, 1, 1, "flush");
        @(negedge clk);
        check("flush.vec_valid", 64'(bus.data_out_valid), 64'(1));
        check("flush.vec", 64'(dut_vec()), 64'(32'h00006655));
        for (int i = 0; i < 4; i++) drive_cycle(W'(8'h70 + i), 1, 1, 0, "after_flush");
        @(negedge clk);
        check("after_flush.vec", 64'(dut_vec()), 64'(32'h73727170));
        drive_cycle('0, 0, 1, 0, "after_flush_drain");
`endif

        drive_cycle('0, 0, 1, 0, "final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/carousel_word_packer.md
Name: carousel_word_packer

Overview:
- Serial-to-parallel stage directly upstream of the carousel rotator.
- Accepts one WIDTH-bit word per handshake and packs BUFFER_SIZE consecutive words into one vector.
- Presents the vector on a valid/ready interface that matches the rotator's parallel data_in.
- Ping-pong double-buffered, so the next vector fills while the current one waits for the rotator.

Parameters:
- WIDTH, 8, bits per word/lane.
- BUFFER_SIZE, 16, lanes per output vector (>= 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- data_in  input  WIDTH  serial input word.
- data_in_valid  input  1  data_in holds a valid word.
- data_in_ready  output  1  packer can accept a word this cycle.
- data_out  output  WIDTH x BUFFER_SIZE (unpacked array [BUFFER_SIZE-1:0])  packed vector.
- data_out_valid  output  1  data_out holds a complete vector.
- data_out_ready  input  1  downstream accepts the vector.

Behaviour:
- State:
  - bank[2][BUFFER_SIZE] of WIDTH-bit regs.
  - full[1:0] flags.
  - wr_sel and rd_sel, 1 bit each.
  - fill_cnt, $clog2(BUFFER_SIZE) bits.
- Reset (rst=0, async): all bank regs 0, full=2'b00, wr_sel=0, rd_sel=0, fill_cnt=0. Outputs during and after reset: data_in_ready=1, data_out_valid=0, data_out all 0.
- data_in_ready = !full[wr_sel] (combinational from registers only; no input-to-output path).
- Input handshake (data_in_valid && data_in_ready):
  - Write bank[wr_sel][fill_cnt] <= data_in.
  - If fill_cnt==BUFFER_SIZE-1: full[wr_sel]<=1, wr_sel toggles, fill_cnt<=0.
  - Otherwise fill_cnt increments.
- Lane order: first accepted word goes to lane 0, last to lane BUFFER_SIZE-1.
- data_out = bank[rd_sel]; data_out_valid = full[rd_sel].
- Output handshake (data_out_valid && data_out_ready): full[rd_sel]<=0, rd_sel toggles. Bank contents are not cleared.
- Latency: data_out_valid rises the cycle after the BUFFER_SIZE-th word handshake.
- Throughput: 1 word/cycle sustained while the consumer drains at least one vector per BUFFER_SIZE cycles.
- Stall/hold rules:
  - Both banks full -> data_in_ready=0 until an output handshake; ready returns the cycle after.
  - data_out is stable while data_out_valid=1 and data_out_ready=0.
- Simultaneous events:
  - Last-word fill and output handshake in the same cycle always target different banks; both updates take effect.
  - Input while the other bank drains proceeds normally.
- data_in_valid while data_in_ready=0: ignored; no state change.
- fill_cnt wrap: returns to 0 exactly on lane BUFFER_SIZE-1; it never exceeds BUFFER_SIZE-1 (also for non-power-of-2 sizes).
- Reset mid-fill or mid-output: partial vector is discarded and all state returns to reset values immediately.

Optional Feature:
- Macro: CAROUSEL_PACKER_FLUSH_EN.
- With macro defined:
  - Adds input port data_in_last (1 bit), sampled with the input handshake.
  - A handshake with data_in_last=1 writes the word to lane fill_cnt and marks the bank full.
  - Lanes fill_cnt+1 .. BUFFER_SIZE-1 of that bank are written 0 in the same cycle.
  - wr_sel toggles and fill_cnt resets to 0.
  - data_in_last on lane BUFFER_SIZE-1 behaves as a normal fill.
- Without macro: no data_in_last port; vectors complete only after BUFFER_SIZE words.

Test Plan (WIDTH=8, BUFFER_SIZE=4):
- Reset then stream words 0x11,0x22,0x33,0x44 with data_out_ready=1 -> one cycle after the 4th handshake, data_out_valid=1 and data_out[0..3]=11,22,33,44; vector accepted; data_in_ready stays 1 throughout.
- data_out_ready=0, stream 12 words 0x01..0x0C -> data_in_ready drops to 0 after word 0x08. Then raise data_out_ready:
  - vector {01,02,03,04} is emitted first, then {05,06,07,08}.
  - data_in_ready returns to 1 the cycle after the first output handshake.
  - word 0x09 is then accepted into lane 0.
- Continuous 1 word/cycle input, data_out_ready=1 -> a valid vector every 4 cycles; data_in_ready never deasserts.
- Back-pressure hold: data_out_ready toggles randomly over 3 vectors -> data_out is stable whenever valid&&!ready; no words lost or reordered.
- Assert rst=0 asynchronously (mid-cycle) after 2 words of a fill -> data_out_valid=0 and data_in_ready=1 immediately. Next 4 words 0xA0..0xA3 form vector {A0,A1,A2,A3}.
- (CAROUSEL_PACKER_FLUSH_EN) Words 0x55, 0x66 with data_in_last=1 on 0x66 -> vector {55,66,00,00} valid next cycle; the following fill starts at lane 0.
